seg_adder: RTL
==============

SEG_ADDER -- requirements
Module: seg_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; SEGS = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port d_a  input  WIDTH  operand A.
REQ-008 SHALL have port d_b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  WIDTH  registered sum/difference.
REQ-014 SHALL have port cout  output  1  raw carry-out of MSB chunk (sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid && in_ready, SHALL latch d_a, d_b, cin, sub, clear segment counter, enter BUSY; otherwise stay IDLE.
REQ-018 add: result = A + B + cin; sub: result = A + ~B + ~cin (= A - B - cin); operands mod 2^WIDTH.
REQ-019 BUSY: SHALL add one CHUNK-wide slice per cycle, LSB slice first, carrying between slices via an internal carry register.
REQ-020 BUSY: after slice SEGS-1 is written, SHALL enter DONE; accept edge N -> out_valid high after edge N+SEGS.
REQ-021 ovf SHALL be set when MSB carry-in differs from MSB carry-out, computed on the final slice.
REQ-022 DONE: result, cout, ovf SHALL hold stable until out_valid && out_ready, then enter IDLE.
REQ-023 in_valid while BUSY or DONE SHALL be ignored (no queuing, no overlap); operand inputs changing after acceptance SHALL not affect the result.
REQ-024 result, cout, ovf SHALL retain last completed values in IDLE; partially written result bits during BUSY are not valid.
REQ-025 WIDTH == CHUNK SHALL give SEGS = 1, latency 1 cycle.

Reset
REQ-026 rstn low SHALL asynchronously force IDLE, result = 0, cout = 0, ovf = 0, carry register = 0, segment counter = 0.
REQ-027 Reset during BUSY or DONE SHALL discard the operation; no out_valid pulse follows reset release.
REQ-028 After reset release, in_ready SHALL be 1 and out_valid 0.

Configuration
REQ-029 Macro SEG_ADDER_SAT_EN: when defined, on entering DONE SHALL clamp result to all-ones if add with cout = 1, to zero if sub with cout = 0 (unsigned saturation); cout/ovf unchanged.
REQ-030 Without SEG_ADDER_SAT_EN, result SHALL wrap mod 2^WIDTH with no clamping logic present.

Structure
REQ-031 Package seg_adder_pkg SHALL hold the FSM state enum typedef and mode constants (MODE_ADD, MODE_SUB).
REQ-032 Sub-module seg_adder_chunk SHALL be a combinational CHUNK-bit slice adder (a, b, ci -> s, co, MSB carry-in) instantiated once in seg_adder.

Verification (WIDTH = 16, CHUNK = 4)
REQ-033 add 100 + 50, cin = 0 -> out_valid 4 cycles after accept, result = 150, cout = 0, ovf = 0.
REQ-034 add 65535 + 1 -> result = 0, cout = 1 (with SEG_ADDER_SAT_EN: result = 65535); add 0x7FFF + 1 -> 0x8000, ovf = 1.
REQ-035 sub 200 - 50 -> 150, cout = 1; sub 50 - 200 -> 65386, cout = 0 (with SEG_ADDER_SAT_EN: 0).
REQ-036 out_ready held low 5 cycles in DONE -> result stable, in_ready = 0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-037 rstn pulsed low in 2nd BUSY cycle -> immediate IDLE, result = 0, no out_valid; next op 1 + 2 -> 3.

Source files
------------

// File: rtl/seg_adder_pkg.sv
// Shared types and constants for the segmented (chunk-serial) adder.
package seg_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/seg_adder_chunk.sv
// Combinational CHUNK-bit slice adder; also reports the carry into its MSB
// so the top level can derive signed overflow on the final slice.
module seg_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             msb_ci
);

  logic [CHUNK:0] sum;

  assign sum    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s      = sum[CHUNK-1:0];
  assign co     = sum[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out without a second adder.
  assign msb_ci = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/seg_adder.sv
// Chunk-serial add/subtract: one CHUNK-wide slice per cycle, LSB first.
// Optional unsigned saturation of the result when SEG_ADDER_SAT_EN is defined.
module seg_adder
  import seg_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int SEGS  = WIDTH / CHUNK;
  localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(SEGS - 1);

  state_t           state;
  logic [SEG_W-1:0] seg;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             slice_msb_ci;
  logic [WIDTH-1:0] next_result;

`ifdef SEG_ADDER_SAT_EN
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] r,
                                                  input logic m,
                                                  input logic c);
    if (m == MODE_ADD && c)  return '1;
    if (m == MODE_SUB && !c) return '0;
    return r;
  endfunction
`endif

  assign slice_a = a_q[seg*CHUNK +: CHUNK];
  assign slice_b = b_q[seg*CHUNK +: CHUNK];

  seg_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a      (slice_a),
    .b      (slice_b),
    .ci     (carry),
    .s      (slice_s),
    .co     (slice_co),
    .msb_ci (slice_msb_ci)
  );

  always_comb begin
    next_result = result;
    next_result[seg*CHUNK +: CHUNK] = slice_s;
  end

  // Operand capture: subtraction is folded in here (B and carry inverted once).
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q  <= d_a;
      b_q  <= (sub == MODE_SUB) ? ~d_b : d_b;
      mode <= sub;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      seg       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            seg      <= '0;
            carry    <= (sub == MODE_SUB) ? ~cin : cin;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          result <= next_result;
          carry  <= slice_co;
          seg    <= seg + 1'b1;
          if (seg == LAST_SEG) begin
`ifdef SEG_ADDER_SAT_EN
            result <= sat_result(next_result, mode, slice_co);
`endif
            cout      <= slice_co;
            ovf       <= slice_co ^ slice_msb_ci;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
